// File: rtl/reg_file_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: FSM state encoding,
// register-file address limit and default bus widths.
package reg_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 8;

    localparam logic [5:0] REG_MAX_ADDR = 6'h1F;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ISSUE  = 2'd1;
    localparam logic [1:0] RDWAIT = 2'd2;

    function automatic logic addr_in_range(input logic [31:0] addr);
        return addr <= 32'(REG_MAX_ADDR);
    endfunction

endpackage

// File: rtl/reg_file_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping, returned as one-hot, index and an any-request flag.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr) + i) % 32'(NUM_REQ));
            if (!any && req[cand]) begin
                any              = 1'b1;
                win_idx          = cand;
                win_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Round-robin arbiter sharing the register-file port between NUM_REQ requesters.
// Optional ARB_LOCK_EN: a locked winner keeps the bus for up to LOCK_MAX grants.
module reg_file_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         rf_address,
    output logic                      rf_write_en,
    output logic [DATA_W-1:0]         rf_wr_data,
    output logic                      rf_read_en,
    input  logic [DATA_W-1:0]         rf_rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_inc;
    logic [IDX_W-1:0]   ptr_next;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [ADDR_W-1:0]  pick_addr;
    logic [DATA_W-1:0]  pick_wdata;
    logic               pick_in_range;

    logic [IDX_W-1:0]   lat_idx;
    logic [NUM_REQ-1:0] lat_onehot;
    logic               lat_we;
    logic               lat_oor;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .ptr        (ptr),
        .win_onehot (pick_onehot),
        .win_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_addr  = req_addr[i*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        pick_in_range = addr_in_range(32'(pick_addr));
    end

    assign ptr_inc = (lat_idx == IDX_W'(NUM_REQ - 1)) ? '0 : lat_idx + 1'b1;

`ifdef ARB_LOCK_EN
    localparam int LCW = $clog2(LOCK_MAX + 1);

    logic [LCW-1:0]   lock_cnt;
    logic [LCW-1:0]   lock_cnt_inc;
    logic [IDX_W-1:0] lock_owner;
    logic             lat_lock;
    logic             lock_hold;

    // Count restarts at 1 whenever the winner differs from the current lock owner.
    always_comb begin
        lock_cnt_inc = (lock_cnt != '0 && lat_idx == lock_owner) ? lock_cnt + 1'b1 : LCW'(1);
        lock_hold    = lat_lock && (32'(lock_cnt_inc) < 32'(LOCK_MAX));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_cnt   <= '0;
            lock_owner <= '0;
            lat_lock   <= 1'b0;
        end else if (state == IDLE && pick_any) begin
            lat_lock <= req_lock[pick_idx];
        end else if (state == ISSUE) begin
            lock_cnt   <= lock_hold ? lock_cnt_inc : '0;
            lock_owner <= lat_idx;
        end
    end

    assign ptr_next = lock_hold ? lat_idx : ptr_inc;
`else
    logic lock_unused;
    assign lock_unused = ^req_lock ^ (LOCK_MAX > 0);
    assign ptr_next    = ptr_inc;
`endif

    // Strobes and gnt are loaded on the IDLE->ISSUE edge so they are live during ISSUE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= '0;
            lat_idx     <= '0;
            lat_onehot  <= '0;
            lat_we      <= 1'b0;
            lat_oor     <= 1'b0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rf_address  <= '0;
            rf_write_en <= 1'b0;
            rf_wr_data  <= '0;
            rf_read_en  <= 1'b0;
        end else begin
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_err     <= 1'b0;
            rf_write_en <= 1'b0;
            rf_read_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        lat_idx    <= pick_idx;
                        lat_onehot <= pick_onehot;
                        lat_we     <= req_we[pick_idx];
                        lat_oor    <= ~pick_in_range;
                        gnt        <= pick_onehot;
                        if (pick_in_range) begin
                            rf_address  <= pick_addr;
                            rf_wr_data  <= pick_wdata;
                            rf_write_en <= req_we[pick_idx];
                            rf_read_en  <= ~req_we[pick_idx];
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    ptr <= ptr_next;
                    if (lat_we) begin
                        if (lat_oor) begin
                            rsp_valid <= lat_onehot;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                        state <= IDLE;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    rsp_valid <= lat_onehot;
                    rsp_rdata <= lat_oor ? '0 : rf_rd_data;
                    rsp_err   <= lat_oor;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed self-checking bench for reg_file_arbiter with a 32-entry register-file model.
`timescale 1ns/1ps
module tb_reg_file_arbiter;

    localparam int NUM_REQ  = 3;
    localparam int ADDR_W   = 6;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 16;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req, req_we, req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt, rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         rf_address;
    logic                      rf_write_en, rf_read_en;
    logic [DATA_W-1:0]         rf_wr_data, rf_rd_data;

    logic [DATA_W-1:0] mem [0:31];
    int checks = 0;
    int errors = 0;
    int n;

    always #5 clock = ~clock;

    reg_file_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rf_address  (rf_address),
        .rf_write_en (rf_write_en),
        .rf_wr_data  (rf_wr_data),
        .rf_read_en  (rf_read_en),
        .rf_rd_data  (rf_rd_data)
    );

    // Register file: entry i resets to 0x95+i, so entry 5 reads 0x9A.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(8'h95 + i);
            rf_rd_data <= '0;
        end else begin
            if (rf_write_en) mem[rf_address[4:0]] <= rf_wr_data;
            if (rf_read_en) rf_rd_data <= mem[rf_address[4:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, gnt, rsp_valid, rsp_rdata, rsp_err, rf_address,
                rf_write_en, rf_wr_data, rf_read_en};
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [5:0] addr,
                           input logic [7:0] wd, input logic lk);
        req[i]                       = 1'b1;
        req_we[i]                    = we;
        req_lock[i]                  = lk;
        req_addr[i*ADDR_W +: ADDR_W] = addr;
        req_wdata[i*DATA_W +: DATA_W] = wd;
    endtask

    task automatic wait_gnt(input int limit, output int cnt);
        bit seen;
        seen = 1'b0;
        cnt  = 0;
        while (!seen && cnt < limit) begin
            @(negedge clock);
            cnt++;
            if (gnt != '0) seen = 1'b1;
        end
        if (!seen) cnt = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("reset_outs", outs(), 32'h0);

        // requester 0 write 0x0C <= 0xC5
        next_cycle(); set_req(0, 1'b1, 6'h0C, 8'hC5, 1'b0);
        @(negedge clock); check("wr_c0_gnt", 32'(gnt), 32'h0);
        next_cycle(); @(negedge clock);
        check("wr_gnt", 32'(gnt), 32'h1);
        check("wr_we", 32'(rf_write_en), 32'h1);
        check("wr_re", 32'(rf_read_en), 32'h0);
        check("wr_addr", 32'(rf_address), 32'h0C);
        check("wr_data", 32'(rf_wr_data), 32'hC5);
        next_cycle(); req[0] = 1'b0; @(negedge clock);
        check("wr_we_pulse", 32'(rf_write_en), 32'h0);
        check("wr_gnt_pulse", 32'(gnt), 32'h0);
        check("wr_no_rsp", 32'(rsp_valid), 32'h0);
        check("wr_mem", 32'(mem[12]), 32'hC5);

        // requester 1 read 0x05
        next_cycle(); set_req(1, 1'b0, 6'h05, 8'h00, 1'b0);
        next_cycle(); @(negedge clock);
        check("rd_gnt", 32'(gnt), 32'h2);
        check("rd_re", 32'(rf_read_en), 32'h1);
        check("rd_we", 32'(rf_write_en), 32'h0);
        check("rd_addr", 32'(rf_address), 32'h05);
        next_cycle(); req[1] = 1'b0; @(negedge clock);
        check("rd_c2_rsp", 32'(rsp_valid), 32'h0);
        next_cycle(); @(negedge clock);
        check("rd_rsp", 32'(rsp_valid), 32'h2);
        check("rd_data", 32'(rsp_rdata), 32'h9A);
        check("rd_err", 32'(rsp_err), 32'h0);

        // requester 2 out-of-range read 0x25
        next_cycle(); set_req(2, 1'b0, 6'h25, 8'h00, 1'b0);
        next_cycle(); @(negedge clock);
        check("oor_rd_gnt", 32'(gnt), 32'h4);
        check("oor_rd_strobe", {30'b0, rf_read_en, rf_write_en}, 32'h0);
        next_cycle(); req[2] = 1'b0; @(negedge clock);
        next_cycle(); @(negedge clock);
        check("oor_rd_rsp", 32'(rsp_valid), 32'h4);
        check("oor_rd_data", 32'(rsp_rdata), 32'h0);
        check("oor_rd_err", 32'(rsp_err), 32'h1);

        // requester 0 out-of-range write 0x20: error response next cycle
        next_cycle(); set_req(0, 1'b1, 6'h20, 8'h77, 1'b0);
        next_cycle(); @(negedge clock);
        check("oor_wr_gnt", 32'(gnt), 32'h1);
        check("oor_wr_we", 32'(rf_write_en), 32'h0);
        next_cycle(); req[0] = 1'b0; @(negedge clock);
        check("oor_wr_rsp", 32'(rsp_valid), 32'h1);
        check("oor_wr_err", 32'(rsp_err), 32'h1);

        // requester 2 write to last in-range address 0x1F
        next_cycle(); set_req(2, 1'b1, 6'h1F, 8'h3C, 1'b0);
        next_cycle(); @(negedge clock);
        check("edge_wr_gnt", 32'(gnt), 32'h4);
        check("edge_wr_we", 32'(rf_write_en), 32'h1);
        next_cycle(); req[2] = 1'b0; @(negedge clock);
        check("edge_wr_mem", 32'(mem[31]), 32'h3C);
        check("edge_wr_rsp", 32'(rsp_valid), 32'h0);

        // all three hold reads: rotation 0,1,2,0,1,2 every 3 cycles
        next_cycle();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 6'(5 + i), 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) begin
            wait_gnt(6, n);
            check("rr_gnt", 32'(gnt), 32'h1 << (k % 3));
            check("rr_gap", 32'(n), (k == 0) ? 32'd2 : 32'd3);
        end
        next_cycle(); req = '0; @(negedge clock);
        next_cycle(); @(negedge clock);
        check("rr_last_rsp", 32'(rsp_valid), 32'h4);
        check("rr_last_data", 32'(rsp_rdata), 32'h9C);

        // reset asserted while requester 1 read sits in RDWAIT
        next_cycle(); set_req(1, 1'b0, 6'h06, 8'h00, 1'b0);
        next_cycle(); @(negedge clock);
        check("rst_rd_gnt", 32'(gnt), 32'h2);
        next_cycle(); req[1] = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("rst_async_outs", outs(), 32'h0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rst_no_rsp", 32'(rsp_valid), 32'h0);
            next_cycle();
        end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 6'(8'h10 + i), 8'h11, 1'b0);
        wait_gnt(6, n);
        check("rst_first_gnt", 32'(gnt), 32'h1);
        check("rst_first_lat", 32'(n), 32'd2);
        next_cycle(); req = '0; @(negedge clock);

`ifdef ARB_LOCK_EN
        // requester 1 locked with 0 and 2 requesting: 16 grants to 1, then 2
        next_cycle();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 6'(8'h08 + i), 8'h22, i == 1);
        for (int k = 0; k <= LOCK_MAX; k++) begin
            wait_gnt(6, n);
            check("lock_gnt", 32'(gnt), (k < LOCK_MAX) ? 32'h2 : 32'h4);
        end
        next_cycle(); req = '0; req_lock = '0; @(negedge clock);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
Shares the single address/write/read port of the motor/servo register file between NUM_REQ requesters (SPI host link, debug UART, internal angle poller). Round-robin arbitration, one transaction in flight, registered strobes toward the register file and a read-response path back to the winning requester. Sits between the requester front-ends and reg_file in the FPGA subsystem.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_W, 6, register address width
DATA_W, 8, register data width
LOCK_MAX, 16, max back-to-back grants to a locked requester (ARB_LOCK_EN only)

Ports:
clock  in  1  main clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester transaction request, held until gnt
req_we  in  NUM_REQ  1=write, 0=read
req_lock  in  NUM_REQ  hold bus after this transaction (ignored unless ARB_LOCK_EN)
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data
gnt  out  NUM_REQ  one-hot, one-cycle pulse when transaction issued
rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse with read data / error
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  out-of-range access flag, valid with rsp_valid
rf_address  out  ADDR_W  to register file address
rf_write_en  out  1  to register file write enable
rf_wr_data  out  DATA_W  to register file write data
rf_read_en  out  1  to register file read enable
rf_rd_data  in  DATA_W  from register file (registered there, 1-cycle latency)

Behaviour:
- Reset (async, reset_n=0): state IDLE; gnt, rsp_valid, rf_write_en, rf_read_en = 0; rf_address, rf_wr_data, rsp_rdata = 0; rsp_err=0; rr pointer=0 (requester 0 highest priority); lock count=0.
- All outputs registered.
- States: IDLE, ISSUE, RDWAIT.
- IDLE: if |req, winner = first set bit searching from ptr upward with wrap; latch index, we, addr, wdata; -> ISSUE. Else stay.
- ISSUE (1 cycle): gnt[win]=1. If addr<=6'h1F: rf_address=addr; rf_write_en=we; rf_read_en=~we; rf_wr_data=wdata. If addr>=6'h20: no rf strobe (both 0). ptr=win+1 mod NUM_REQ. Write -> IDLE. Read -> RDWAIT. Out-of-range write -> IDLE, rsp_valid[win]=1 with rsp_err=1 on the next cycle.
- RDWAIT: capture rf_rd_data (or 0x00 if out of range) into rsp_rdata; rsp_err=out-of-range; rsp_valid[win]=1 on following cycle; -> IDLE.
- Timing: req seen cycle 0 -> gnt/strobe cycle 1 -> write in register file at end of cycle 1; read rsp_valid cycle 3. Writes every 2 cycles, reads every 3.
- Requester drops req in the cycle after gnt; still-high req next IDLE is a new transaction. Latched transaction completes even if req falls after latching; req dropped before IDLE sampling is never granted.
- Fairness: with all requesting, grants rotate 0,1,2,0,…; wait bound NUM_REQ-1 transactions.
- Addresses 0x01-0x03 (broadcast) forwarded unchanged; no special handling.
- Reset mid-transaction: transaction abandoned, no rsp_valid, strobes drop immediately.

Optional Feature:
ARB_LOCK_EN: when defined, if req_lock[win]=1 at latch, ptr is not advanced and next IDLE grants win again if req[win]=1, up to LOCK_MAX consecutive grants, then rotation forced; lock count clears when another requester wins. Undefined: req_lock ignored, pure round-robin.

Decomposition:
- Package reg_arb_pkg: state encoding (IDLE/ISSUE/RDWAIT), REG_MAX_ADDR=6'h1F, default ADDR_W/DATA_W.
- Sub-module rr_picker: combinational round-robin (req, ptr -> one-hot winner, index, any).

Test Plan:
- Requester 0 write addr 0x0C data 0xC5 -> gnt[0] cycle 1, rf_write_en=1, rf_address=0x0C, rf_wr_data=0xC5 for exactly one cycle; no rsp_valid.
- Requester 1 read 0x05, model returns 0x9A -> rf_read_en pulse cycle 1, rsp_valid[1]=1 cycle 3, rsp_rdata=0x9A, rsp_err=0.
- All three hold read reqs continuously -> gnt order 0,1,2,0,1,2; no requester waits >2 transactions.
- Requester 2 read addr 0x25 -> no rf strobe, rsp_valid[2]=1, rsp_rdata=0x00, rsp_err=1.
- Assert reset_n=0 in RDWAIT -> all outputs 0 asynchronously, no rsp_valid after release; next grant goes to requester 0.
- ARB_LOCK_EN, requester 1 locked with 0 and 2 requesting -> 16 consecutive gnt[1], then gnt[2].
